// File: rtl/sa_weight_load_stage.sv
// sa_weight_load_stage: streams one weight matrix row by row into the shadow buffer, then offers the instruction downstream
package xif_pkg;
    localparam int X_ID_WIDTH = 4;
endpackage

module sa_weight_load_stage #(
    parameter int MESH_WIDTH = 4,
    parameter int DATA_WIDTH = 32,
    parameter int N_REGS     = 8,
    localparam int N_ROWS    = MESH_WIDTH,
    localparam int RLEN      = DATA_WIDTH * MESH_WIDTH,
    localparam int RW        = $clog2(N_REGS),
    localparam int CW        = $clog2(N_ROWS),
    localparam int IDW       = xif_pkg::X_ID_WIDTH
) (
    input  logic                                  clk_i,
    input  logic                                  rst_ni,
    input  logic                                  issue_valid_i,
    output logic                                  issue_ready_o,
    input  logic [RW-1:0]                         weight_reg_i,
    input  logic [RW-1:0]                         data_reg_i,
    input  logic [RW-1:0]                         acc_reg_i,
    input  logic [IDW-1:0]                        id_i,
    output logic [RW-1:0]                         weight_raddr_o,
    output logic [CW-1:0]                         weight_rrowaddr_o,
    input  logic [RLEN-1:0]                       weight_rdata_i,
    input  logic                                  weight_rdata_valid_i,
    output logic                                  weight_rdata_ready_o,
    output logic                                  weight_rlast_o,
    output logic                                  wbuf_we_o,
    output logic [CW-1:0]                         wbuf_row_o,
    output logic [MESH_WIDTH-1:0][DATA_WIDTH-1:0] wbuf_wdata_o,
    output logic                                  wl_valid_o,
    input  logic                                  ff_ready_i,
    output logic [RW-1:0]                         data_reg_o,
    output logic [RW-1:0]                         acc_reg_o,
    output logic [IDW-1:0]                        id_o,
    output logic                                  busy_o
);
    typedef enum logic [1:0] {IDLE, LOAD, HANDOFF} state_t;

    state_t         state, state_next;
    logic [CW:0]    row, row_next;
    logic [RW-1:0]  weight_reg, data_reg, acc_reg;
    logic [IDW-1:0] id;
    logic           in_load, beat, issue_fire;

    assign in_load        = state == LOAD;
    assign beat           = in_load & weight_rdata_valid_i;
    assign issue_ready_o  = (state == IDLE) | ((state == HANDOFF) & ff_ready_i);
    assign issue_fire     = issue_valid_i & issue_ready_o;
    assign weight_rlast_o = beat & (row == (CW+1)'(MESH_WIDTH - 1));

    // A new issue always restarts the row count, including the transfer+issue overlap in HANDOFF.
    always_comb begin
        row_next   = issue_fire ? '0 : beat ? row + (CW+1)'(1) : row;
        state_next = (state == IDLE)    ? (issue_fire ? LOAD : IDLE) :
                     (state == LOAD)    ? (weight_rlast_o ? HANDOFF : LOAD) :
                     (state == HANDOFF) ? (ff_ready_i ? (issue_fire ? LOAD : IDLE) : HANDOFF) :
                                          IDLE;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            row        <= '0;
            weight_reg <= '0;
            data_reg   <= '0;
            acc_reg    <= '0;
            id         <= '0;
        end else begin
            state <= state_next;
            row   <= row_next;
            if (issue_fire) begin
                weight_reg <= weight_reg_i;
                data_reg   <= data_reg_i;
                acc_reg    <= acc_reg_i;
                id         <= id_i;
            end
        end
    end

    assign weight_rdata_ready_o = in_load;
    assign weight_raddr_o       = in_load ? weight_reg : '0;
    assign weight_rrowaddr_o    = in_load ? row[CW-1:0] : '0;
    assign wbuf_we_o            = beat;
    assign wbuf_row_o           = beat ? row[CW-1:0] : '0;
    assign wbuf_wdata_o         = beat ? weight_rdata_i : '0;
    assign wl_valid_o           = state == HANDOFF;
    assign data_reg_o           = data_reg;
    assign acc_reg_o            = acc_reg;
    assign id_o                 = id;
    assign busy_o               = state != IDLE;
endmodule
